rgb_gray_stream: RTL and testbench
==================================

RGB_GRAY_STREAM -- requirements
Module: rgb_gray_stream

Interface
REQ-001 Parameter DW, default 8, bit width of each colour channel and of the gray output.
REQ-002 Parameter WIDTH, default 512, pixels per line.
REQ-003 Parameter HEIGHT, default 512, lines per frame.
REQ-004 Parameters CR/CG/CB, defaults 77/150/29, unsigned 9-bit weights with 8 fractional bits.
REQ-005 clk  input  1  single clock; all logic uses the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 s_valid  input  1  input pixel valid.
REQ-008 s_ready  output  1  block accepts the input pixel this cycle.
REQ-009 s_r, s_g, s_b  input  DW each  input colour channels.
REQ-010 m_valid  output  1  output pixel valid.
REQ-011 m_ready  input  1  downstream accepts the output pixel.
REQ-012 m_gray  output  DW  grayscale result.
REQ-013 m_sof, m_eol, m_eof  output  1 each  start-of-frame, end-of-line and end-of-frame tags, aligned with m_gray.

Function
REQ-014 Input transfer occurs when s_valid and s_ready are both high; output transfer occurs when m_valid and m_ready are both high.
REQ-015 Compute gray = (CR*r + CG*g + CB*b + RND) >> 8, where RND is defined in Configuration.
REQ-016 Size the intermediate sum so it does not overflow: 2*DW+11 bits.
REQ-017 Saturate the shifted result to 2^DW-1 when it exceeds DW bits; never wrap.
REQ-018 Use a fixed 3-stage pipeline: S1 registers three products, S2 registers the sum, S3 registers the saturated result and tags.
REQ-019 Latency from input transfer to m_valid is 3 cycles while m_ready is held high; sustained throughput is 1 pixel per cycle.
REQ-020 Global advance enable en = !m_valid || m_ready; s_ready = en, driven combinationally from registered state and m_ready.
REQ-021 Each stage carries a valid bit; bubbles propagate and never produce m_valid.
REQ-022 While m_valid && !m_ready, m_gray and m_sof/m_eol/m_eof hold stable, no pipeline stage advances, and no data is lost or duplicated.
REQ-023 Column counter x (0..WIDTH-1) and row counter y (0..HEIGHT-1) increment on input transfer only.
REQ-024 On input transfer, sof = (x==0 && y==0), eol = (x==WIDTH-1), eof = eol && (y==HEIGHT-1).
REQ-025 When eol is set, x wraps to 0 and y increments; when eof is set, y wraps to 0; the next pixel carries sof.
REQ-026 Tags travel through the pipeline with their pixel, with latency identical to the data.
REQ-027 A cycle with s_valid low or s_ready low leaves x and y unchanged.

Reset
REQ-028 While rst_n is low: all stage valid bits, m_valid, m_gray, the tags, x and y are 0; s_ready is 1 immediately after reset deasserts.
REQ-029 When reset is asserted mid-frame, in-flight pixels are discarded and the next accepted pixel carries sof.

Configuration
REQ-030 Macro GRAY_ROUND_EN defined: RND = 128 (round half up).
REQ-031 Macro GRAY_ROUND_EN undefined: RND = 0 (truncate); all other behaviour is identical.

Verification
REQ-032 Defaults, single pixel (100,150,200), m_ready=1 -> m_gray=140 (141 with GRAY_ROUND_EN) exactly 3 cycles after acceptance.
REQ-033 CR=CG=CB=128, pixel (255,255,255) -> sum 97920, shifted 382 -> m_gray=255 (saturated).
REQ-034 Stream 10 pixels, m_ready low for 5 cycles mid-stream -> s_ready low during the stall, outputs stable, all 10 outputs in order, none lost or duplicated.
REQ-035 WIDTH=4, HEIGHT=2, 9 pixels -> m_sof on pixels 1 and 9; m_eol on pixels 4 and 8; m_eof on pixel 8 only.
REQ-036 rst_n pulsed low after pixel 3 of a WIDTH=4 frame -> m_valid=0 during reset, pipeline flushed, next pixel carries m_sof=1.

Source files
------------

// File: rtl/rgb_gray_stream.sv
// RGB-to-grayscale streaming converter: 3-stage valid/ready pipeline with sof/eol/eof tags.
// Optional macro GRAY_ROUND_EN selects round-half-up; otherwise the result is truncated.
module rgb_gray_stream #(
  parameter int         DW     = 8,
  parameter int         WIDTH  = 512,
  parameter int         HEIGHT = 512,
  parameter logic [8:0] CR     = 9'd77,
  parameter logic [8:0] CG     = 9'd150,
  parameter logic [8:0] CB     = 9'd29
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_r,
  input  logic [DW-1:0] s_g,
  input  logic [DW-1:0] s_b,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_gray,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof
);

  localparam int PW = DW + 9;
  localparam int SW = 2 * DW + 11;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
`ifdef GRAY_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(128);
`else
  localparam logic [SW-1:0] RND = {SW{1'b0}};
`endif

  // Integer part of the weighted sum clamped to the output range.
  function automatic logic [DW-1:0] saturate(input logic [SW-9:0] v);
    if (|v[SW-9:DW]) begin
      return {DW{1'b1}};
    end else begin
      return v[DW-1:0];
    end
  endfunction

  logic          en;
  logic          in_fire;
  logic          sof_in, eol_in, eof_in;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] s1_pr_q, s1_pr_d;
  logic [PW-1:0] s1_pg_q, s1_pg_d;
  logic [PW-1:0] s1_pb_q, s1_pb_d;
  logic [2:0]    s1_tag_q, s1_tag_d;

  // S2 keeps only the integer part of the sum; the fraction is consumed by the shift.
  logic          s2_valid_q, s2_valid_d;
  logic [SW-9:0] s2_sum_q, s2_sum_d;
  logic [2:0]    s2_tag_q, s2_tag_d;

  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_gray_q, m_gray_d;
  logic [2:0]    m_tag_q, m_tag_d;

  // Handshake, frame position tags and column/row counter update.
  always_comb begin
    en      = !m_valid_q || m_ready;
    in_fire = s_valid && en;
    sof_in  = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
    eol_in  = (x_q == X_LAST);
    eof_in  = eol_in && (y_q == Y_LAST);
    x_d     = x_q;
    y_d     = y_q;
    if (in_fire) begin
      if (eol_in) begin
        x_d = {XW{1'b0}};
        if (eof_in) begin
          y_d = {YW{1'b0}};
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Pipeline next state: every stage moves together when en is high, otherwise all hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pr_d    = s1_pr_q;
    s1_pg_d    = s1_pg_q;
    s1_pb_d    = s1_pb_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_tag_d   = s2_tag_q;
    m_valid_d  = m_valid_q;
    m_gray_d   = m_gray_q;
    m_tag_d    = m_tag_q;
    if (en) begin
      s1_valid_d = s_valid;
      s1_pr_d    = PW'(CR) * PW'(s_r);
      s1_pg_d    = PW'(CG) * PW'(s_g);
      s1_pb_d    = PW'(CB) * PW'(s_b);
      s1_tag_d   = {sof_in, eol_in, eof_in};
      s2_valid_d = s1_valid_q;
      s2_sum_d   = (SW-8)'((SW'(s1_pr_q) + SW'(s1_pg_q) + SW'(s1_pb_q) + RND) >> 8);
      s2_tag_d   = s1_tag_q;
      m_valid_d  = s2_valid_q;
      m_gray_d   = saturate(s2_sum_q);
      m_tag_d    = s2_tag_q;
    end else begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      m_valid_d  = m_valid_q;
    end
  end

  // State registers; reset discards in-flight pixels and restarts the frame position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= {XW{1'b0}};
      y_q        <= {YW{1'b0}};
      s1_valid_q <= 1'b0;
      s1_pr_q    <= {PW{1'b0}};
      s1_pg_q    <= {PW{1'b0}};
      s1_pb_q    <= {PW{1'b0}};
      s1_tag_q   <= 3'b000;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= {(SW-8){1'b0}};
      s2_tag_q   <= 3'b000;
      m_valid_q  <= 1'b0;
      m_gray_q   <= {DW{1'b0}};
      m_tag_q    <= 3'b000;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      s1_valid_q <= s1_valid_d;
      s1_pr_q    <= s1_pr_d;
      s1_pg_q    <= s1_pg_d;
      s1_pb_q    <= s1_pb_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_tag_q   <= s2_tag_d;
      m_valid_q  <= m_valid_d;
      m_gray_q   <= m_gray_d;
      m_tag_q    <= m_tag_d;
    end
  end

  assign s_ready = en;
  assign m_valid = m_valid_q;
  assign m_gray  = m_gray_q;
  assign m_sof   = m_tag_q[2];
  assign m_eol   = m_tag_q[1];
  assign m_eof   = m_tag_q[0];

endmodule

// File: tb/tb_rgb_gray_stream.sv
// Self-checking bench for rgb_gray_stream: randomized pixels against an arithmetic reference
// model, a second instance with all weights 128 for saturation, WIDTH=4 / HEIGHT=2 for tags.
module tb_rgb_gray_stream;

  localparam int W = 4;
  localparam int H = 2;
`ifdef GRAY_ROUND_EN
  localparam int RND        = 128;
  localparam int EXP_SINGLE = 141;
`else
  localparam int RND        = 0;
  localparam int EXP_SINGLE = 140;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] s_r     = 8'd0;
  logic [7:0] s_g     = 8'd0;
  logic [7:0] s_b     = 8'd0;
  logic       s_ready, m_valid, m_sof, m_eol, m_eof;
  logic [7:0] m_gray;
  logic       sat_s_ready, sat_m_valid, sat_sof, sat_eol, sat_eof;
  logic [7:0] sat_gray;

  typedef struct {
    int gray;
    bit sof;
    bit eol;
    bit eof;
    int cyc;
  } pix_t;

  pix_t exp_q[$];
  pix_t obs_q[$];
  int   exp_sat_q[$];
  int   obs_sat_q[$];
  int   pix_n    = 0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rgb_gray_stream #(.DW(8), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_r(s_r), .s_g(s_g), .s_b(s_b), .m_valid(m_valid), .m_ready(m_ready),
    .m_gray(m_gray), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  rgb_gray_stream #(.DW(8), .WIDTH(W), .HEIGHT(H), .CR(9'd128), .CG(9'd128), .CB(9'd128)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sat_s_ready),
    .s_r(s_r), .s_g(s_g), .s_b(s_b), .m_valid(sat_m_valid), .m_ready(m_ready),
    .m_gray(sat_gray), .m_sof(sat_sof), .m_eol(sat_eol), .m_eof(sat_eof)
  );

  always #5 clk = ~clk;

  function automatic int ref_gray(int cr, int cg, int cb, int r, int g, int b);
    int v;
    v = (cr * r + cg * g + cb * b + RND) / 256;
    return (v > 255) ? 255 : v;
  endfunction

  // One clock: record accepted pixels into the model and delivered pixels into the observed queue.
  task automatic tick(output bit acc);
    pix_t p;
    int   pos;
    @(negedge clk);
    acc = s_valid && s_ready;
    if (acc) begin
      pos    = pix_n % (W * H);
      p.gray = ref_gray(77, 150, 29, int'(s_r), int'(s_g), int'(s_b));
      p.sof  = (pos == 0);
      p.eol  = ((pos % W) == W - 1);
      p.eof  = (pos == W * H - 1);
      p.cyc  = cyc;
      exp_q.push_back(p);
      exp_sat_q.push_back(ref_gray(128, 128, 128, int'(s_r), int'(s_g), int'(s_b)));
      pix_n++;
    end
    if (m_valid && m_ready) begin
      p.gray = int'(m_gray);
      p.sof  = m_sof;
      p.eol  = m_eol;
      p.eof  = m_eof;
      p.cyc  = cyc;
      obs_q.push_back(p);
    end
    if (sat_m_valid && m_ready) obs_sat_q.push_back(int'(sat_gray));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    exp_q.delete();
    obs_q.delete();
    exp_sat_q.delete();
    obs_sat_q.delete();
    pix_n = 0;
  endtask

  task automatic do_reset();
    bit a;
    s_valid = 1'b0;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    #1;
    clear_model();
    tick(a);
    tick(a);
    rst_n = 1'b1;
  endtask

  // Let the pipeline empty, then run a few extra cycles so duplicated outputs would show up.
  task automatic drain(output bit ok);
    bit a;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) tick(a);
    ok = (obs_q.size() >= exp_q.size());
    for (int i = 0; i < 4; i++) tick(a);
  endtask

  task automatic new_pixel();
    s_r = 8'($urandom_range(0, 255));
    s_g = 8'($urandom_range(0, 255));
    s_b = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    #2;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    #3;
    n_checks++;
    if (m_valid !== 1'b0 || m_gray !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%b gray=%0d, expected valid=0 gray=0", m_valid, m_gray);
    end
    n_checks++;
    if ({m_sof, m_eol, m_eof} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_tags: got %b, expected 000", {m_sof, m_eol, m_eof});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_s_ready: got %b, expected 1", s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bit a, ok;
    do_reset();
    s_valid = 1'b1;
    s_r = 8'd100;
    s_g = 8'd150;
    s_b = 8'd200;
    a = 1'b0;
    for (int i = 0; i < 5 && !a; i++) tick(a);
    drain(ok);
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d outputs, expected 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].gray != EXP_SINGLE || obs_q[0].gray != exp_q[0].gray) begin
        n_fail++;
        $display("FAIL single_gray: got %0d, expected %0d", obs_q[0].gray, EXP_SINGLE);
      end
      n_checks++;
      if (obs_q[0].cyc - exp_q[0].cyc != 3) begin
        n_fail++;
        $display("FAIL single_latency: got %0d cycles, expected 3", obs_q[0].cyc - exp_q[0].cyc);
      end
      n_checks++;
      if (obs_q[0].sof !== 1'b1) begin
        n_fail++;
        $display("FAIL single_sof: got %b, expected 1", obs_q[0].sof);
      end
    end
  endtask

  task automatic test_saturation();
    bit a, ok;
    do_reset();
    s_valid = 1'b1;
    s_r = 8'd255;
    s_g = 8'd255;
    s_b = 8'd255;
    tick(a);
    new_pixel();
    tick(a);
    drain(ok);
    n_checks++;
    if (obs_sat_q.size() != 2 || exp_sat_q.size() != 2) begin
      n_fail++;
      $display("FAIL sat_count: got %0d outputs, expected 2", obs_sat_q.size());
    end else begin
      n_checks++;
      if (obs_sat_q[0] != 255) begin
        n_fail++;
        $display("FAIL sat_white: got %0d, expected 255", obs_sat_q[0]);
      end
      n_checks++;
      if (obs_sat_q[1] != exp_sat_q[1]) begin
        n_fail++;
        $display("FAIL sat_random: got %0d, expected %0d", obs_sat_q[1], exp_sat_q[1]);
      end
    end
  endtask

  task automatic test_stall();
    bit         a, ok;
    int         sent;
    logic [7:0] held_gray;
    logic [2:0] held_tag;
    do_reset();
    sent = 0;
    new_pixel();
    for (int c = 0; c < 60 && sent < 10; c++) begin
      s_valid = 1'b1;
      m_ready = !(c >= 6 && c < 11);
      #1;
      if (c >= 6 && c < 11) begin
        n_checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_ready: cycle %0d got s_ready=%b m_valid=%b, expected 0 and 1", c, s_ready, m_valid);
        end
        if (c == 6) begin
          held_gray = m_gray;
          held_tag  = {m_sof, m_eol, m_eof};
        end else begin
          n_checks++;
          if (m_gray !== held_gray || {m_sof, m_eol, m_eof} !== held_tag) begin
            n_fail++;
            $display("FAIL stall_hold: cycle %0d got gray=%0d tags=%b, expected gray=%0d tags=%b",
                     c, m_gray, {m_sof, m_eol, m_eof}, held_gray, held_tag);
          end
        end
      end
      tick(a);
      if (a) begin
        sent++;
        new_pixel();
      end
    end
    drain(ok);
    n_checks++;
    if (!ok || obs_q.size() != 10 || exp_q.size() != 10) begin
      n_fail++;
      $display("FAIL stall_count: got %0d outputs, expected 10", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].gray != exp_q[i].gray || obs_q[i].sof != exp_q[i].sof ||
          obs_q[i].eol != exp_q[i].eol || obs_q[i].eof != exp_q[i].eof) begin
        n_fail++;
        $display("FAIL stall_pix[%0d]: got gray=%0d tags=%b%b%b, expected gray=%0d tags=%b%b%b", i,
                 obs_q[i].gray, obs_q[i].sof, obs_q[i].eol, obs_q[i].eof,
                 exp_q[i].gray, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof);
      end
    end
  endtask

  task automatic test_tags();
    bit a, ok;
    int sent;
    do_reset();
    sent = 0;
    new_pixel();
    s_valid = 1'b1;
    for (int c = 0; c < 30 && sent < 9; c++) begin
      tick(a);
      if (a) begin
        sent++;
        new_pixel();
      end
    end
    drain(ok);
    n_checks++;
    if (obs_q.size() != 9) begin
      n_fail++;
      $display("FAIL tags_count: got %0d outputs, expected 9", obs_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (obs_q[i].sof != (i == 0 || i == 8) || obs_q[i].eol != (i == 3 || i == 7) ||
            obs_q[i].eof != (i == 7) || obs_q[i].gray != exp_q[i].gray) begin
          n_fail++;
          $display("FAIL tags_pix[%0d]: got sof=%b eol=%b eof=%b gray=%0d, expected sof=%b eol=%b eof=%b gray=%0d",
                   i + 1, obs_q[i].sof, obs_q[i].eol, obs_q[i].eof, obs_q[i].gray,
                   (i == 0 || i == 8), (i == 3 || i == 7), (i == 7), exp_q[i].gray);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit a, ok;
    int sent;
    do_reset();
    sent = 0;
    new_pixel();
    s_valid = 1'b1;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      tick(a);
      if (a) begin
        sent++;
        new_pixel();
      end
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_valid: step %0d got m_valid=%b, expected 0", i, m_valid);
      end
      tick(a);
    end
    rst_n = 1'b1;
    s_valid = 1'b1;
    a = 1'b0;
    for (int i = 0; i < 5 && !a; i++) tick(a);
    drain(ok);
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d outputs, expected 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].sof !== 1'b1 || obs_q[0].gray != exp_q[0].gray) begin
        n_fail++;
        $display("FAIL midrst_pix: got sof=%b gray=%0d, expected sof=1 gray=%0d",
                 obs_q[0].sof, obs_q[0].gray, exp_q[0].gray);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit a, ok;
    int sent;
    do_reset();
    sent = 0;
    new_pixel();
    for (int c = 0; c < 400 && sent < 40; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      tick(a);
      if (a) begin
        sent++;
        new_pixel();
      end
    end
    drain(ok);
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size() || exp_q.size() != 40) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs, expected %0d of 40", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].gray != exp_q[i].gray || obs_q[i].sof != exp_q[i].sof ||
          obs_q[i].eol != exp_q[i].eol || obs_q[i].eof != exp_q[i].eof) begin
        n_fail++;
        $display("FAIL b2b_pix[%0d]: got gray=%0d tags=%b%b%b, expected gray=%0d tags=%b%b%b", i,
                 obs_q[i].gray, obs_q[i].sof, obs_q[i].eol, obs_q[i].eof,
                 exp_q[i].gray, exp_q[i].sof, exp_q[i].eol, exp_q[i].eof);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_stall();
    test_tags();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
